motor_layer_out_serializer: RTL and testbench

Reader-side counterpart of the per-layer ReLU stage. It captures one parallel ReLU result frame of N_CH ap_fixed<32,8> words through a valid/ack handshake. It replays the frame one word per beat on a valid/ready stream toward the MPC/dSPACE host interface. It decouples the combinational layer datapath from host-side backpressure and counts completed frames.

---
 rtl/motor_ser_pkg.sv | 16 +
 rtl/motor_layer_out_serializer.sv | 123 ++++++++++++
 tb/tb_motor_layer_out_serializer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_ser_pkg.sv
// Shared constants and types for the ReLU-layer output serializer.
package motor_ser_pkg;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned W     = 32;
  localparam int unsigned IDX_W = $clog2(N_CH);

  // Q8.24 fixed-point word (ap_fixed<32,8>)
  typedef logic [W-1:0] q8_24_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/motor_layer_out_serializer.sv
// Captures one N_CH-word ReLU frame and replays it word by word on a valid/ready stream.
// Optional MOTOR_SER_TLAST_EN adds an out_last marker on the final channel beat.
module motor_layer_out_serializer
  import motor_ser_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic                in_vld,
  output logic                in_ack,
  output logic [W-1:0]        out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_vld,
  input  logic                out_rdy,
`ifdef MOTOR_SER_TLAST_EN
  output logic                out_last,
`endif
  output logic                busy,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  state_e              state_q, state_d;
  q8_24_t              hold_q [N_CH];
  q8_24_t              hold_d [N_CH];
  q8_24_t              out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic                out_vld_q, out_vld_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                last_beat;
  logic                capture;
  logic [IDX_W-1:0]    idx_nxt;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '{default: '0};
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_vld_q   <= out_vld_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state, word mux and handshake; a capture overrides the SEND update so frames chain without a bubble.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_vld_d   = out_vld_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    idx_nxt     = out_idx_q + IDX_W'(1);
    last_beat   = (state_q == SEND) && out_rdy && (out_idx_q == LAST_IDX);
    in_ack      = (state_q == IDLE) || last_beat;
    capture     = in_vld && in_ack;

    case (state_q)
      IDLE: begin
        out_vld_d = 1'b0;
        busy_d    = 1'b0;
      end
      SEND: begin
        if (out_rdy) begin
          if (out_idx_q != LAST_IDX) begin
            out_idx_d  = idx_nxt;
            out_data_d = hold_q[idx_nxt];
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = IDLE;
            out_vld_d   = 1'b0;
            busy_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      for (int k = 0; k < N_CH; k++) begin
        hold_d[k] = in_data[k*W +: W];
      end
      out_data_d = in_data[W-1:0];
      out_idx_d  = '0;
      out_vld_d  = 1'b1;
      busy_d     = 1'b1;
      state_d    = SEND;
    end
  end

`ifdef MOTOR_SER_TLAST_EN
  logic out_last_q;

  // Derived from the next beat so it changes only when out_data/out_idx do.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) out_last_q <= 1'b0;
    else           out_last_q <= out_vld_d && (out_idx_d == LAST_IDX);
  end

  assign out_last = out_last_q;
`endif

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_vld   = out_vld_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_motor_layer_out_serializer.sv
// Directed self-checking bench for motor_layer_out_serializer (default and narrow-counter instances).
module tb_motor_layer_out_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] in_data;
  logic        in_vld;
  logic        in_ack;
  logic [31:0] out_data;
  logic [1:0]  out_idx;
  logic        out_vld;
  logic        out_rdy;
  logic        busy;
  logic [15:0] frame_cnt;
`ifdef MOTOR_SER_TLAST_EN
  logic        out_last;
  logic        out_last2;
`endif

  logic [95:0] in_data2;
  logic        in_vld2;
  logic        in_ack2;
  logic [31:0] out_data2;
  logic [1:0]  out_idx2;
  logic        out_vld2;
  logic        out_rdy2;
  logic        busy2;
  logic [3:0]  frame_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  motor_layer_out_serializer dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_ack    (in_ack),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
`ifdef MOTOR_SER_TLAST_EN
    .out_last  (out_last),
`endif
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  motor_layer_out_serializer #(.CNT_W(4)) dut_w (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_data   (in_data2),
    .in_vld    (in_vld2),
    .in_ack    (in_ack2),
    .out_data  (out_data2),
    .out_idx   (out_idx2),
    .out_vld   (out_vld2),
    .out_rdy   (out_rdy2),
`ifdef MOTOR_SER_TLAST_EN
    .out_last  (out_last2),
`endif
    .busy      (busy2),
    .frame_cnt (frame_cnt2)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b1;
    in_vld2 = 1'b0; in_data2 = '0; out_rdy2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({out_vld, busy, out_idx, out_data, frame_cnt} !== 51'd0) begin
      n_err++;
      $display("FAIL reset_state: vld=%b busy=%b idx=%0d data=%h cnt=%0d, want all 0",
               out_vld, busy, out_idx, out_data, frame_cnt);
    end
    n_cmp++;
    if (in_ack !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ack: got %b want 1", in_ack);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [31:0] w [3];
    w = '{32'h0100_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    @(negedge clk);
    in_data = {w[2], w[1], w[0]}; in_vld = 1'b1; out_rdy = 1'b1;
    #1;
    n_cmp++;
    if (in_ack !== 1'b1 || out_vld !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: ack=%b vld=%b want ack=1 vld=0", in_ack, out_vld);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_vld = 1'b0;
      #1;
      n_cmp++;
      if (out_vld !== 1'b1 || busy !== 1'b1 || out_idx !== 2'(k) || out_data !== w[k]
          || in_ack !== (k == 2)) begin
        n_err++;
        $display("FAIL single_beat%0d: vld=%b busy=%b idx=%0d data=%h ack=%b want 1 1 %0d %h %b",
                 k, out_vld, busy, out_idx, out_data, in_ack, k, w[k], (k == 2));
      end
`ifdef MOTOR_SER_TLAST_EN
      n_cmp++;
      if (out_last !== (k == 2)) begin
        n_err++;
        $display("FAIL single_last%0d: got %b want %b", k, out_last, (k == 2));
      end
`endif
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (out_vld !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL single_done: vld=%b busy=%b cnt=%0d want 0 0 1", out_vld, busy, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    w = '{32'h0100_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    @(negedge clk);
    in_data = {w[2], w[1], w[0]}; in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    n_cmp++;
    if (out_idx !== 2'd0 || out_data !== w[0]) begin
      n_err++;
      $display("FAIL bp_first: idx=%0d data=%h want 0 %h", out_idx, out_data, w[0]);
    end
    @(negedge clk);
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    for (int s = 0; s < 4; s++) begin
      #1;
      n_cmp++;
      if (out_vld !== 1'b1 || out_idx !== 2'd1 || out_data !== 32'h0 || in_ack !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall%0d: vld=%b idx=%0d data=%h ack=%b want 1 1 0 0",
                 s, out_vld, out_idx, out_data, in_ack);
      end
`ifdef MOTOR_SER_TLAST_EN
      n_cmp++;
      if (out_last !== 1'b0) begin
        n_err++;
        $display("FAIL bp_last_stall%0d: got %b want 0", s, out_last);
      end
`endif
      @(negedge clk);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    #1;
    n_cmp++;
    if (out_idx !== 2'd1 || out_data !== 32'h0) begin
      n_err++;
      $display("FAIL bp_release: idx=%0d data=%h want 1 0", out_idx, out_data);
    end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    n_cmp++;
    if (out_idx !== 2'd2 || out_data !== w[2] || in_ack !== 1'b0) begin
      n_err++;
      $display("FAIL bp_last_hold: idx=%0d data=%h ack=%b want 2 %h 0", out_idx, out_data, in_ack, w[2]);
    end
`ifdef MOTOR_SER_TLAST_EN
    n_cmp++;
    if (out_last !== 1'b1) begin
      n_err++;
      $display("FAIL bp_last_flag: got %b want 1", out_last);
    end
`endif
    @(negedge clk);
    out_rdy = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (out_vld !== 1'b0 || frame_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL bp_done: vld=%b cnt=%0d want 0 2", out_vld, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [6];
    int beats;
    exp = '{32'h0100_0000, 32'h0000_0000, 32'h7FFF_FFFF,
            32'h0080_0000, 32'h0200_0000, 32'h0000_0001};
    beats = 0;
    @(negedge clk);
    in_data = {exp[2], exp[1], exp[0]}; in_vld = 1'b1; out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_vld = (c == 2);
      if (c == 2) in_data = {exp[5], exp[4], exp[3]};
      #1;
      if (out_vld === 1'b1) beats++;
      n_cmp++;
      if (out_vld !== 1'b1 || out_idx !== 2'(c % 3) || out_data !== exp[c]) begin
        n_err++;
        $display("FAIL b2b_beat%0d: vld=%b idx=%0d data=%h want 1 %0d %h",
                 c, out_vld, out_idx, out_data, c % 3, exp[c]);
      end
      if (c == 2) begin
        n_cmp++;
        if (in_ack !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ack: got %b want 1", in_ack);
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (beats != 6 || out_vld !== 1'b0 || frame_cnt !== 16'd4) begin
      n_err++;
      $display("FAIL b2b_done: beats=%0d vld=%b cnt=%0d want 6 0 4", beats, out_vld, frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    in_data = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001}; in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (out_vld !== 1'b0 || frame_cnt !== 16'd0 || in_ack !== 1'b1 || busy !== 1'b0
        || out_idx !== 2'd0 || out_data !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid: vld=%b cnt=%0d ack=%b busy=%b idx=%0d data=%h want 0 0 1 0 0 0",
               out_vld, frame_cnt, in_ack, busy, out_idx, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_vld !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stale%0d: vld=%b data=%h want vld 0", c, out_vld, out_data);
      end
    end
  endtask

  task automatic test_negative_passthru();
    @(negedge clk);
    in_data = {32'h8000_0000, 32'hFFFF_FFFF, 32'hC000_0001}; in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    n_cmp++;
    if (out_data !== 32'hC000_0001) begin
      n_err++;
      $display("FAIL neg_w0: got %h want c0000001", out_data);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (out_data !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL neg_w1: got %h want ffffffff", out_data);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (out_data !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL neg_w2: got %h want 80000000", out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    in_data2 = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010}; in_vld2 = 1'b1; out_rdy2 = 1'b1;
    for (int c = 1; c <= 49; c++) begin
      @(negedge clk);
      in_vld2 = (c < 48);
      #1;
      if (c % 3 == 1 && c > 1) begin
        n_cmp++;
        if (frame_cnt2 !== 4'((c - 1) / 3)) begin
          n_err++;
          $display("FAIL wrap_cnt_c%0d: got %0d want %0d", c, frame_cnt2, 4'((c - 1) / 3));
        end
      end
    end
    n_cmp++;
    if (out_vld2 !== 1'b0 || frame_cnt2 !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_end: vld=%b cnt=%0d want 0 0", out_vld2, frame_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_negative_passthru();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
